button_event_decoder: RTL and testbench

Input-side user-interface block: conditions the three raw push-buttons (btnU, btnR, btnL) into clean, single-cycle events for the clock/time-setting logic that feeds the seven-segment display subsystem. Each button is synchronized, debounced, and decoded into press, release, and auto-repeat events, plus a held level. It sits between the board pins and the switch/time logic. It is the input counterpart of the display driver's output path.

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_channel.sv | 154 +++++++++++++++
 rtl/button_event_decoder.sv | 68 ++++++
 tb/tb_button_event_decoder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button event decoder.
//   btn_state_t : per-channel debounce/repeat FSM state
//   BTN_U/R/L   : bit index of each button in the 3-bit event vectors
//   NUM_BTNS    : number of button channels
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    REPEATING,
    DEB_RELEASE
  } btn_state_t;

  localparam int unsigned BTN_U    = 0;
  localparam int unsigned BTN_R    = 1;
  localparam int unsigned BTN_L    = 2;
  localparam int unsigned NUM_BTNS = 3;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold/repeat
// timing. All outputs are registered.
//   clk, reset     : system clock, synchronous active-high reset
//   btn_raw        : raw asynchronous button level (active-high)
//   press_pulse    : one-cycle pulse on accepted press
//   release_pulse  : one-cycle pulse on accepted release
//   repeat_pulse   : one-cycle auto-repeat pulse while held
//   held           : debounced level
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned MAX_TIME = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_TIME);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_t       state_q, state_d;
  logic             orig_rep_q, orig_rep_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // run/run_rep: this edge advances the hold/repeat timer as if in
  // PRESSED (run_rep=0) or REPEATING (run_rep=1).
  logic run;
  logic run_rep;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    state_d    = state_q;
    orig_rep_d = orig_rep_q;
    hold_cnt_d = hold_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;
    held_d     = held_q;
    run        = 1'b0;
    run_rep    = 1'b0;

    // The entry edge already counts as the first stable sample, so the
    // debounce counter starts at 1 and completes at DEBOUNCE_CYCLES-1.
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d    = DEB_PRESS;
          deb_cnt_d  = DEB_W'(1);
          hold_cnt_d = '0;
        end
      end
      DEB_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          held_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED, REPEATING: begin
        if (!sync2_q) begin
          state_d    = DEB_RELEASE;
          deb_cnt_d  = DEB_W'(1);
          orig_rep_d = (state_q == REPEATING);
        end else begin
          run     = 1'b1;
          run_rep = (state_q == REPEATING);
        end
      end
      DEB_RELEASE: begin
        // A bounce back high resumes the frozen timer on this same edge.
        if (sync2_q) begin
          run     = 1'b1;
          run_rep = orig_rep_q;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (run) begin
      if (hold_cnt_q == (run_rep ? REPEAT_LAST : HOLD_LAST)) begin
        repeat_d   = 1'b1;
        hold_cnt_d = '0;
        state_d    = REPEATING;
      end else begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        state_d    = run_rep ? REPEATING : PRESSED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= IDLE;
      orig_rep_q <= 1'b0;
      hold_cnt_q <= '0;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      orig_rep_q <= orig_rep_d;
      hold_cnt_q <= hold_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: rtl/button_event_decoder.sv
// Conditions three raw push-buttons into clean single-cycle events.
//   clk, reset         : system clock, synchronous active-high reset
//   btnU, btnR, btnL   : raw asynchronous buttons (active-high)
//   press_pulse[2:0]   : one-cycle pulse on accepted press  ([0]=U [1]=R [2]=L)
//   release_pulse[2:0] : one-cycle pulse on accepted release
//   repeat_pulse[2:0]  : one-cycle auto-repeat pulse while held
//   held[2:0]          : debounced level
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btnU,
  input  logic                btnR,
  input  logic                btnL,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse,
  output logic [NUM_BTNS-1:0] held
);

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_chan_u (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btnU),
    .press_pulse  (press_pulse[BTN_U]),
    .release_pulse(release_pulse[BTN_U]),
    .repeat_pulse (repeat_pulse[BTN_U]),
    .held         (held[BTN_U])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_chan_r (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btnR),
    .press_pulse  (press_pulse[BTN_R]),
    .release_pulse(release_pulse[BTN_R]),
    .repeat_pulse (repeat_pulse[BTN_R]),
    .held         (held[BTN_R])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_chan_l (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btnL),
    .press_pulse  (press_pulse[BTN_L]),
    .release_pulse(release_pulse[BTN_L]),
    .repeat_pulse (repeat_pulse[BTN_L]),
    .held         (held[BTN_L])
  );

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with DEBOUNCE=4, HOLD=10, REPEAT=3.
// Table entry i: button levels applied before edge i, outputs expected after it.
module tb_button_event_decoder;

  localparam int N = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnU = 1'b0, btnR = 1'b0, btnL = 1'b0;
  logic [2:0] press_pulse, release_pulse, repeat_pulse, held;

  always #5 clk = ~clk;

  button_event_decoder #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btnU         (btnU),
    .btnR         (btnR),
    .btnL         (btnL),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  typedef struct {
    logic [2:0] btn;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] rep;
    logic [2:0] held;
  } vec_t;

  vec_t vec [N];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic tick(input logic [2:0] b, input logic rst);
    @(negedge clk);
    {btnL, btnR, btnU} = b;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] ep, input logic [2:0] er,
                       input logic [2:0] erp, input logic [2:0] eh);
    n_cmp++;
    if ({press_pulse, release_pulse, repeat_pulse, held} !== {ep, er, erp, eh}) begin
      n_bad++;
      $display("FAIL %s: press/rel/rep/held got %b/%b/%b/%b want %b/%b/%b/%b", name,
               press_pulse, release_pulse, repeat_pulse, held, ep, er, erp, eh);
    end
  endtask

  task automatic set_btn(input int b, input int from, input int to);
    for (int i = from; i < to; i++) vec[i].btn[b] = 1'b1;
  endtask

  task automatic set_held(input int b, input int from, input int to);
    for (int i = from; i < to; i++) vec[i].held[b] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) vec[i] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    // Clean btnU press sampled from edge 10, released from edge 20.
    set_btn(0, 10, 20);
    vec[15].press[0] = 1'b1; set_held(0, 15, 25); vec[25].rel[0] = 1'b1;

    // btnR bounces (3 high, 1 low, 2 high, 1 low) then stable from edge 47.
    set_btn(1, 40, 43); set_btn(1, 44, 46); set_btn(1, 47, 58);
    vec[52].press[1] = 1'b1; set_held(1, 52, 63); vec[63].rel[1] = 1'b1;

    // btnL held 30 cycles past press: repeats at 95 + 3n, release 5 after first low.
    set_btn(2, 80, 115);
    vec[85].press[2] = 1'b1;
    for (int t = 95; t <= 116; t += 3) vec[t].rep[2] = 1'b1;
    set_held(2, 85, 120); vec[120].rel[2] = 1'b1;

    // btnU repeating with a 2-cycle low glitch at 152..153: cadence slips by 2.
    set_btn(0, 130, 152); set_btn(0, 154, 163);
    vec[135].press[0] = 1'b1;
    vec[145].rep[0] = 1'b1; vec[148].rep[0] = 1'b1; vec[151].rep[0] = 1'b1;
    vec[156].rep[0] = 1'b1; vec[159].rep[0] = 1'b1; vec[162].rep[0] = 1'b1;
    set_held(0, 135, 168); vec[168].rel[0] = 1'b1;

    // All three pressed on the same edge.
    for (int b = 0; b < 3; b++) begin
      set_btn(b, 180, 190);
      vec[185].press[b] = 1'b1; set_held(b, 185, 195); vec[195].rel[b] = 1'b1;
    end

    // Reset state, with a button high during reset that must not leak through.
    for (int i = 0; i < 3; i++) begin
      tick(3'b010, 1'b1);
      check($sformatf("reset%0d", i), 3'b000, 3'b000, 3'b000, 3'b000);
    end

    for (int i = 0; i < N; i++) begin
      tick(vec[i].btn, 1'b0);
      check($sformatf("vec%0d", i), vec[i].press, vec[i].rel, vec[i].rep, vec[i].held);
    end

    // btnR held, reset mid-operation, then reset released with btnR still high.
    for (int i = 0; i < 8; i++) begin
      tick(3'b010, 1'b0);
      check($sformatf("pre_rst%0d", i), (i == 5) ? 3'b010 : 3'b000, 3'b000, 3'b000,
            (i >= 5) ? 3'b010 : 3'b000);
    end
    tick(3'b010, 1'b1);
    check("mid_reset", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(3'b010, 1'b1);
    check("mid_reset2", 3'b000, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 9; i++) begin
      tick(3'b010, 1'b0);
      check($sformatf("post_rst%0d", i), (i == 5) ? 3'b010 : 3'b000, 3'b000, 3'b000,
            (i >= 5) ? 3'b010 : 3'b000);
    end

    // Release after the post-reset press; short timer so no repeat yet.
    for (int i = 0; i < 6; i++) begin
      tick(3'b000, 1'b0);
      check($sformatf("post_rel%0d", i), 3'b000, (i == 5) ? 3'b010 : 3'b000, 3'b000,
            (i < 5) ? 3'b010 : 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
